regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources: the ALU and the load unit.

---
 rtl/regfile_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Shares the register file's single write port between the ALU and the
//   load unit. Also keeps a pending-write scoreboard (busy_mask) that the
//   issue stage uses for RAW hazard stalls.
//   Arbitration: the load unit wins by default. The ALU wins when there is no
//   load request. It also wins after it has lost STARVE_LIMIT consecutive
//   cycles. The granted write reaches the register file one cycle later.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   alu_valid/ready/index/value     ALU writeback request (valid/ready)
//   mem_valid/ready/index/value     load-unit writeback request (valid/ready)
//   reserve_valid, reserve_index    issue stage claims a destination register
//   busy_mask                       bit n set = write to xn pending
//   write_enabled/index/value       register file write port (registered)
//
// Configuration macro: REGFILE_BYPASS_EN
//   When defined, this macro adds read_index_1/2 (in), read1_bypass/read2_bypass
//   (out) and bypass_value (out). The outputs are registered forwarding of the
//   committing write.
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 3   // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_index,
    input  logic [31:0] alu_value,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_index,
    input  logic [31:0] mem_value,
    input  logic        reserve_valid,
    input  logic [4:0]  reserve_index,
    output logic [31:0] busy_mask,
    output logic        write_enabled,
    output logic [4:0]  write_index,
    output logic [31:0] write_value
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic [4:0]  read_index_1,
    input  logic [4:0]  read_index_2,
    output logic        read1_bypass,
    output logic        read2_bypass,
    output logic [31:0] bypass_value
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_q, starve_d;
    logic [31:0] busy_q, busy_d;
    logic        we_q, we_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] val_q, val_d;

    logic        alu_grant;
    logic        mem_grant;
    logic [4:0]  grant_index;
    logic [31:0] grant_value;

    // The ALU is granted when there is no load request, or when its starvation
    // limit is reached. The load unit takes every other cycle it requests.
    assign alu_grant   = alu_valid && (!mem_valid || (starve_q == LIMIT));
    assign mem_grant   = mem_valid && !alu_grant;
    assign alu_ready   = alu_grant;
    assign mem_ready   = mem_grant;
    assign grant_index = alu_grant ? alu_index : mem_index;
    assign grant_value = alu_grant ? alu_value : mem_value;

    // NOTE: every output of this block gets a default value first. Any path
    // that does not assign a variable would otherwise infer a latch.
    always_comb begin
        starve_d = 4'd0;
        busy_d   = busy_q;
        we_d     = 1'b0;
        idx_d    = idx_q;
        val_d    = val_q;

        if (alu_valid && !alu_grant) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
        end

        // Apply the clear first and the set second. If a new producer reserves
        // the register in the same cycle as the old write commits, the bit stays 1.
        if (we_q) begin
            busy_d[idx_q] = 1'b0;
        end
        if (reserve_valid) begin
            busy_d[reserve_index] = 1'b1;
        end
        busy_d[0] = 1'b0;

        // A grant to x0 completes the handshake. The write is dropped and the
        // write port keeps its last index/value.
        if ((alu_grant || mem_grant) && (grant_index != 5'd0)) begin
            we_d  = 1'b1;
            idx_d = grant_index;
            val_d = grant_value;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All registers
    // update together on the edge, and processes cannot race each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 4'd0;
            busy_q   <= 32'd0;
            we_q     <= 1'b0;
            idx_q    <= 5'd0;
            val_q    <= 32'd0;
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
        end
    end

    assign busy_mask     = busy_q;
    assign write_enabled = we_q;
    assign write_index   = idx_q;
    assign write_value   = val_q;

`ifdef REGFILE_BYPASS_EN
    logic        byp1_q, byp2_q;
    logic [31:0] byp_val_q;

    // This forwards the value committing this cycle to readers of the same
    // register. The register file read in this same cycle still returns stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            byp1_q    <= 1'b0;
            byp2_q    <= 1'b0;
            byp_val_q <= 32'd0;
        end else begin
            byp1_q <= we_q && (idx_q != 5'd0) && (idx_q == read_index_1);
            byp2_q <= we_q && (idx_q != 5'd0) && (idx_q == read_index_2);
            if (we_q) begin
                byp_val_q <= val_q;
            end
        end
    end

    assign read1_bypass = byp1_q;
    assign read2_bypass = byp2_q;
    assign bypass_value = byp_val_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Purpose:
//   Self-checking bench for regfile_write_arbiter. At each grant it pushes the
//   expected register-file write into a queue. It pops and compares that write
//   in the following cycle. Readies, busy_mask and (with REGFILE_BYPASS_EN)
//   the bypass outputs are checked against a small behavioural model every cycle.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int LIMIT = 3;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] val;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, reserve_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_index, mem_index, reserve_index;
    logic [31:0] alu_value, mem_value;
    logic [31:0] busy_mask;
    logic        write_enabled;
    logic [4:0]  write_index;
    logic [31:0] write_value;
`ifdef REGFILE_BYPASS_EN
    logic [4:0]  read_index_1, read_index_2;
    logic        read1_bypass, read2_bypass;
    logic [31:0] bypass_value;
`endif

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_index(alu_index), .alu_value(alu_value),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_index(mem_index), .mem_value(mem_value),
        .reserve_valid(reserve_valid), .reserve_index(reserve_index),
        .busy_mask(busy_mask),
        .write_enabled(write_enabled), .write_index(write_index),
        .write_value(write_value)
`ifdef REGFILE_BYPASS_EN
        ,
        .read_index_1(read_index_1), .read_index_2(read_index_2),
        .read1_bypass(read1_bypass), .read2_bypass(read2_bypass),
        .bypass_value(bypass_value)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural model state.
    wr_t         wq[$];
    int          m_starve = 0;
    logic [31:0] m_busy   = 32'd0;
    logic [4:0]  m_idx    = 5'd0;
    logic [31:0] m_val    = 32'd0;
    logic        m_b1 = 1'b0, m_b2 = 1'b0;
    logic [31:0] m_bval   = 32'd0;
    logic        g_alu, g_mem;

    // This task runs one clock cycle. At the falling edge it checks the outputs
    // against the model and advances the model. It returns #1 after the rising edge.
    task automatic cycle();
        logic exp_we;
        wr_t  e;
        @(negedge clk);
        exp_we = 1'b0;
        e      = '0;
        if (wq.size() > 0) begin
            e      = wq.pop_front();
            exp_we = 1'b1;
            m_idx  = e.idx;
            m_val  = e.val;
        end
        check("write_enabled", {31'd0, write_enabled}, {31'd0, exp_we});
        check("write_index", {27'd0, write_index}, {27'd0, m_idx});
        check("write_value", write_value, m_val);
        check("busy_mask", busy_mask, m_busy);
`ifdef REGFILE_BYPASS_EN
        check("read1_bypass", {31'd0, read1_bypass}, {31'd0, m_b1});
        check("read2_bypass", {31'd0, read2_bypass}, {31'd0, m_b2});
        check("bypass_value", bypass_value, m_bval);
`endif
        g_alu = alu_valid && (!mem_valid || (m_starve == LIMIT));
        g_mem = mem_valid && !g_alu;
        check("alu_ready", {31'd0, alu_ready}, {31'd0, g_alu});
        check("mem_ready", {31'd0, mem_ready}, {31'd0, g_mem});

        if (reset) begin
            wq.delete();
            m_starve = 0;
            m_busy   = 32'd0;
            m_idx    = 5'd0;
            m_val    = 32'd0;
            m_b1     = 1'b0;
            m_b2     = 1'b0;
            m_bval   = 32'd0;
        end else begin
            if (alu_valid && !g_alu) m_starve = (m_starve == LIMIT) ? LIMIT : m_starve + 1;
            else                     m_starve = 0;
            if (exp_we) m_busy[e.idx] = 1'b0;
            if (reserve_valid && reserve_index != 5'd0) m_busy[reserve_index] = 1'b1;
`ifdef REGFILE_BYPASS_EN
            m_b1 = exp_we && (e.idx != 5'd0) && (e.idx == read_index_1);
            m_b2 = exp_we && (e.idx != 5'd0) && (e.idx == read_index_2);
            if (exp_we) m_bval = e.val;
`endif
            if (g_alu && alu_index != 5'd0) wq.push_back('{idx: alu_index, val: alu_value});
            if (g_mem && mem_index != 5'd0) wq.push_back('{idx: mem_index, val: mem_value});
        end
        @(posedge clk);
        #1;
    endtask

    int alu_win_cycle;
    int mem_after;

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_index = '0; alu_value = '0;
        mem_valid = 1'b0; mem_index = '0; mem_value = '0;
        reserve_valid = 1'b0; reserve_index = '0;
`ifdef REGFILE_BYPASS_EN
        read_index_1 = '0; read_index_2 = '0;
`endif
        @(posedge clk); #1;
        cycle();                      // reset held: outputs show reset values
        reset = 1'b0;
        cycle();

        // 1: both valid, mem wins first, ALU follows.
        mem_valid = 1'b1; mem_index = 5'd5; mem_value = 32'hAAAA_0001;
        alu_valid = 1'b1; alu_index = 5'd6; alu_value = 32'h0000_1234;
        cycle();
        check("t1_mem_first", {31'd0, g_mem}, 32'd1);
        mem_valid = 1'b0;
        cycle();
        check("t1_alu_second", {31'd0, g_alu}, 32'd1);
        alu_valid = 1'b0;
        cycle();

        // 2: starvation. mem requests every cycle, ALU force-granted on 4th.
        alu_win_cycle = -1;
        mem_after = 0;
        alu_valid = 1'b1; alu_index = 5'd10; alu_value = 32'h0A0A_0A0A;
        mem_valid = 1'b1; mem_index = 5'd11; mem_value = 32'h1100_0000;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (g_alu) begin
                alu_win_cycle = i;
                alu_valid = 1'b0;
            end
            if (g_mem) begin
                if (alu_win_cycle >= 0) mem_after++;
                mem_index = mem_index + 5'd1;
                mem_value = mem_value + 32'd1;
            end
        end
        mem_valid = 1'b0;
        check("t2_alu_win_cycle", alu_win_cycle, 32'd3);
        check("t2_mem_resumed", mem_after, 32'd3);
        cycle();

        // 3: reserve x7, ALU commit clears it; then reserve again on commit.
        reserve_valid = 1'b1; reserve_index = 5'd7;
        cycle();
        reserve_valid = 1'b0;
        alu_valid = 1'b1; alu_index = 5'd7; alu_value = 32'h7777_0007;
        cycle();
        check("t3_busy_set", busy_mask, 32'h80);
        alu_valid = 1'b0;
        cycle();                      // commit cycle
        cycle();
        check("t3_busy_clr", busy_mask, 32'h0);
        reserve_valid = 1'b1;
        cycle();
        reserve_valid = 1'b0;
        alu_valid = 1'b1; alu_value = 32'h7777_0008;
        cycle();
        alu_valid = 1'b0;
        reserve_valid = 1'b1;         // reserve again in the commit cycle
        cycle();
        reserve_valid = 1'b0;
        cycle();
        check("t3_busy_kept", busy_mask, 32'h80);

        // 4: grant to x0 is dropped; reserve x0 ignored.
        alu_valid = 1'b1; alu_index = 5'd0; alu_value = 32'hFFFF_FFFF;
        reserve_valid = 1'b1; reserve_index = 5'd0;
        cycle();
        check("t4_x0_ready", {31'd0, g_alu}, 32'd1);
        alu_valid = 1'b0; reserve_valid = 1'b0;
        cycle();
        check("t4_x0_no_write", {31'd0, write_enabled}, 32'd0);
        check("t4_busy0", {31'd0, busy_mask[0]}, 32'd0);

        // 5a: reset in the cycle after a grant. The write already registered still
        // appears, then everything clears.
        mem_valid = 1'b1; mem_index = 5'd12; mem_value = 32'h1212_1212;
        cycle();
        mem_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("t5a_we_after_reset", {31'd0, write_enabled}, 32'd0);
        check("t5a_busy_after_reset", busy_mask, 32'd0);
        // 5b: reset in the grant cycle discards the in-flight write.
        reserve_valid = 1'b1; reserve_index = 5'd13;
        cycle();
        reserve_valid = 1'b0;
        mem_valid = 1'b1; mem_index = 5'd13; mem_value = 32'h1313_1313;
        reset = 1'b1;
        cycle();
        mem_valid = 1'b0;
        reset = 1'b0;
        cycle();
        check("t5b_no_stale_write", {31'd0, write_enabled}, 32'd0);
        check("t5b_busy_cleared", busy_mask, 32'd0);
        cycle();
        cycle();

`ifdef REGFILE_BYPASS_EN
        // 6: bypass of committing x9.
        read_index_1 = 5'd9; read_index_2 = 5'd3;
        alu_valid = 1'b1; alu_index = 5'd9; alu_value = 32'hDEAD_BEEF;
        cycle();
        alu_valid = 1'b0;
        cycle();                      // commit
        cycle();
        check("t6_read1_bypass", {31'd0, read1_bypass}, 32'd1);
        check("t6_read2_bypass", {31'd0, read2_bypass}, 32'd0);
        check("t6_bypass_value", bypass_value, 32'hDEAD_BEEF);
        cycle();
`endif

        // Random traffic against the model, including reserves.
        for (int i = 0; i < 200; i++) begin
            if (!alu_valid) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_index = 5'($urandom);
                alu_value = $urandom;
            end
            if (!mem_valid) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_index = 5'($urandom);
                mem_value = $urandom;
            end
            reserve_valid = 1'($urandom_range(0, 1));
            reserve_index = 5'($urandom);
`ifdef REGFILE_BYPASS_EN
            read_index_1 = 5'($urandom);
            read_index_2 = 5'($urandom);
`endif
            cycle();
            if (g_alu) alu_valid = 1'b0;
            if (g_mem) mem_valid = 1'b0;
        end
        alu_valid = 1'b0; mem_valid = 1'b0; reserve_valid = 1'b0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
